// File: rtl/sync_fifo_ctrl.sv
// Pointer and flag controller for a FIFO around an external dual-port memory
// with asynchronous read; the read side is first-word-fall-through.
module sync_fifo_ctrl #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic              mem_wren,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic [AWIDTH-1:0] mem_raddr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [AWIDTH:0]   count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [AWIDTH:0] PTR_ONE    = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH:0] AFULL_LVL  = (AWIDTH+1)'(AFULL_TH);
  localparam logic [AWIDTH:0] AEMPTY_LVL = (AWIDTH+1)'(AEMPTY_TH);

  logic [AWIDTH:0] wptr_r;
  logic [AWIDTH:0] rptr_r;
  logic            overflow_r;
  logic            underflow_r;

  logic            empty_s;
  logic            full_s;
  logic [AWIDTH:0] count_s;
  logic            wr_acc_s;
  logic            rd_acc_s;
  logic            ovf_set_s;
  logic            udf_set_s;

  // Status decode from registered pointers; handshakes only qualify transfers
  always_comb begin
    empty_s   = (wptr_r == rptr_r);
    full_s    = (wptr_r[AWIDTH-1:0] == rptr_r[AWIDTH-1:0]) &&
                (wptr_r[AWIDTH] != rptr_r[AWIDTH]);
    count_s   = wptr_r - rptr_r;
    wr_acc_s  = wr_valid && !full_s;
    rd_acc_s  = rd_ready && !empty_s;
    ovf_set_s = wr_valid && full_s;
    udf_set_s = rd_ready && empty_s;
  end

  // Pointer registers; each advances only on an accepted transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (wr_acc_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle takes priority over clr_err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end
      if (udf_set_s) begin
        underflow_r <= 1'b1;
      end else if (clr_err) begin
        underflow_r <= 1'b0;
      end
    end
  end

  assign wr_ready     = !full_s;
  assign rd_valid     = !empty_s;
  assign rd_data      = mem_rdata;
  assign mem_wren     = wr_acc_s;
  assign mem_waddr    = wptr_r[AWIDTH-1:0];
  assign mem_wdata    = wr_data;
  assign mem_raddr    = rptr_r[AWIDTH-1:0];
  assign count        = count_s;
  assign almost_full  = (count_s >= AFULL_LVL);
  assign almost_empty = (count_s <= AEMPTY_LVL);
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomized scoreboard bench for sync_fifo_ctrl: a queue-based FIFO model plus
// a behavioural memory; a negedge monitor compares status and popped data.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       rd_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, rd_valid, mem_wren;
  logic [7:0] rd_data, mem_wdata, mem_rdata;
  logic [3:0] mem_waddr, mem_raddr;
  logic [4:0] count;
  logic       almost_full, almost_empty, overflow, underflow;

  logic [7:0] mem [16];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_data[$];
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic       exp_wren = 1'b0;

  sync_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_wren(mem_wren), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) mem[mem_waddr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: status against the model, read data against the scoreboard
  always @(negedge clk) begin
    int n;
    n = m_data.size();
    chk("count", 32'(count), 32'(n));
    chk("wr_ready", 32'(wr_ready), 32'(n != 16));
    chk("rd_valid", 32'(rd_valid), 32'(n != 0));
    chk("almost_full", 32'(almost_full), 32'(n >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("mem_wren", 32'(mem_wren), 32'(exp_wren));
    if (n != 0) chk("rd_data_head", 32'(rd_data), 32'(m_data[0]));
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) chk("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
      else chk("sb_rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  // One clock of stimulus; model state is committed just after the edge
  task automatic step(input logic wv, input logic [7:0] wd, input logic rr, input logic ce);
    logic wacc, racc;
    int   n;
    n = m_data.size();
    wr_valid = wv; wr_data = wd; rd_ready = rr; clr_err = ce;
    wacc = wv && (n < 16);
    racc = rr && (n > 0);
    exp_wren = wacc;
    if (wacc) exp_q.push_back(wd);
    @(posedge clk); #1;
    if (racc) void'(m_data.pop_front());
    if (wacc) m_data.push_back(wd);
    m_ovf = (wv && n == 16) ? 1'b1 : (ce ? 1'b0 : m_ovf);
    m_udf = (rr && n == 0) ? 1'b1 : (ce ? 1'b0 : m_udf);
  endtask

  task automatic mid_reset();
    #3;
    wr_valid = 1'b0; rd_ready = 1'b0; clr_err = 1'b0; exp_wren = 1'b0;
    rst = 1'b1;
    m_data.delete(); exp_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    chk("rst_count_immediate", 32'(count), 32'd0);
    chk("rst_rd_valid_immediate", 32'(rd_valid), 32'd0);
    chk("rst_wr_ready_immediate", 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_almost_empty", 32'(almost_empty), 32'd1);
    chk("reset_mem_wren", 32'(mem_wren), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single word, visible the cycle after it is written
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_rd_data", 32'(rd_data), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // fill with 0x00..0x0F, then a 17th write overflows
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd16);
    step(1'b1, 8'h10, 1'b0, 1'b0);
    chk("overflow_set", 32'(overflow), 32'd1);

    // clear, re-trigger, clear with simultaneous overflow condition
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b1);
    chk("overflow_set_wins", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // full with read: write still refused while the read completes
    step(1'b1, 8'h13, 1'b1, 1'b0);

    // drain remaining words in order, then one extra read underflows
    while (m_data.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("underflow_set", 32'(underflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // steady state at five entries with pointers wrapping
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("steady_count", 32'(count), 32'd5);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 55), 8'($urandom),
           1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 5));

    // asynchronous reset mid-cycle at nine entries
    while (m_data.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("pre_reset_count", 32'(count), 32'd9);
    mid_reset();

    for (int i = 0; i < 30; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("scoreboard_residue", 32'(exp_q.size()), 32'(m_data.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
